// File: rtl/ppu_vga_scanout_pkg.sv
// Shared VGA 640x480@60 timing constants, image window geometry and the NES master palette.
package vga_timing_defs;

   localparam int H_VIS    = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS    = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int IMG_W    = 512;
   localparam int H_OFFSET = (H_VIS - IMG_W) / 2;
   localparam int H_WIN_END = H_OFFSET + IMG_W;

   // 2C02 colours reduced to the top nibble of each 8-bit channel, stored as {R,G,B}.
   localparam logic [11:0] NES_PALETTE [64] = '{
      12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
      12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
      12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
      12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
      12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
      12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
      12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
      12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
   };

endpackage

// File: rtl/ppu_vga_scanout_palette.sv
// NES palette ROM: 6-bit palette index to 12-bit RGB, purely combinational.
module nes_palette_rom
   import vga_timing_defs::*;
(
   input  logic [5:0]  i_index,
   output logic [11:0] o_rgb
);

   always_comb begin
      o_rgb = NES_PALETTE[i_index];
   end

endmodule

// File: rtl/ppu_vga_scanout.sv
// PPU frame-buffer scanout: VGA timing with the 256x240 image doubled into a centred 512x480 window.
// Stage 0 counters and read issue, stage 1 read data return, stage 2 registered palette lookup.
module ppu_vga_scanout #(
   parameter int H_VIS    = vga_timing_defs::H_VIS,
   parameter int H_FP     = vga_timing_defs::H_FP,
   parameter int H_SYNC   = vga_timing_defs::H_SYNC,
   parameter int H_BP     = vga_timing_defs::H_BP,
   parameter int V_VIS    = vga_timing_defs::V_VIS,
   parameter int V_FP     = vga_timing_defs::V_FP,
   parameter int V_SYNC   = vga_timing_defs::V_SYNC,
   parameter int V_BP     = vga_timing_defs::V_BP,
   parameter int H_OFFSET = vga_timing_defs::H_OFFSET
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_pix_ce,
   output logic [15:0] o_fb_addr,
   output logic        o_fb_rd_en,
   input  logic [7:0]  i_fb_data,
   output logic        o_vga_done,
   output logic        o_frame_start,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic [3:0]  o_red,
   output logic [3:0]  o_green,
   output logic [3:0]  o_blue
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] L_H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0] L_V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0] L_H_VIS    = 10'(H_VIS);
   localparam logic [9:0] L_V_VIS    = 10'(V_VIS);
   localparam logic [9:0] L_HS_BEG   = 10'(H_VIS + H_FP);
   localparam logic [9:0] L_HS_END   = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] L_VS_BEG   = 10'(V_VIS + V_FP);
   localparam logic [9:0] L_VS_END   = 10'(V_VIS + V_FP + V_SYNC);
   localparam logic [9:0] L_WIN_BEG  = 10'(H_OFFSET);
   localparam logic [9:0] L_WIN_END  = 10'(H_OFFSET + vga_timing_defs::IMG_W);

   logic [9:0]  r_hCnt;
   logic [9:0]  r_vCnt;
   logic [15:0] r_fbAddr;
   logic        r_fbRdEn;
   logic        r_vgaDone;
   logic        r_frameStart;

   logic [9:0]  w_hNext;
   logic [9:0]  w_vNext;
   logic [9:0]  w_col;
   logic        w_lineEnd;
   logic        w_frameWrap;
   logic        w_doneSet;
   logic        w_nextInWin;
   logic        w_hsync0;
   logic        w_vsync0;
   logic        w_de0;

   logic        r_win1;
   logic        r_hs1;
   logic        r_vs1;
   logic        r_de1;
   logic        r_hs2;
   logic        r_vs2;
   logic        r_de2;
   logic [11:0] r_rgb;
   logic [11:0] w_palRgb;
   logic        w_unusedBits;

   // Next counter position; read strobe and address are registered from it so they line up with h_cnt/v_cnt.
   always_comb begin
      w_lineEnd   = (r_hCnt == L_H_LAST);
      w_frameWrap = w_lineEnd && (r_vCnt == L_V_LAST);
      w_hNext     = r_hCnt + 10'd1;
      w_vNext     = r_vCnt;
      if (w_lineEnd) begin
         w_hNext = '0;
         w_vNext = (r_vCnt == L_V_LAST) ? 10'd0 : r_vCnt + 10'd1;
      end
      w_doneSet   = w_lineEnd && (w_vNext == L_V_VIS);
      w_col       = w_hNext - L_WIN_BEG;
      w_nextInWin = (w_hNext >= L_WIN_BEG) && (w_hNext < L_WIN_END) && (w_vNext < L_V_VIS);
   end

   always_comb begin
      w_hsync0 = !((r_hCnt >= L_HS_BEG) && (r_hCnt < L_HS_END));
      w_vsync0 = !((r_vCnt >= L_VS_BEG) && (r_vCnt < L_VS_END));
      w_de0    = (r_hCnt < L_H_VIS) && (r_vCnt < L_V_VIS);
   end

   // Counters, read issue and the vga_done flag; the address holds outside the window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hCnt       <= '0;
         r_vCnt       <= '0;
         r_fbAddr     <= '0;
         r_fbRdEn     <= 1'b0;
         r_vgaDone    <= 1'b0;
         r_frameStart <= 1'b0;
      end else if (i_pix_ce) begin
         r_hCnt       <= w_hNext;
         r_vCnt       <= w_vNext;
         r_fbRdEn     <= w_nextInWin;
         r_frameStart <= w_frameWrap;
         if (w_nextInWin) begin
            r_fbAddr <= {w_vNext[8:1], w_col[8:1]};
         end
         if (w_frameWrap) begin
            r_vgaDone <= 1'b0;
         end else if (w_doneSet) begin
            r_vgaDone <= 1'b1;
         end
      end
   end

   nes_palette_rom u_palette (
      .i_index (i_fb_data[5:0]),
      .o_rgb   (w_palRgb)
   );

   // Window flag and syncs ride alongside the returning read data, then colour is registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_win1 <= 1'b0;
         r_hs1  <= 1'b1;
         r_vs1  <= 1'b1;
         r_de1  <= 1'b0;
         r_hs2  <= 1'b1;
         r_vs2  <= 1'b1;
         r_de2  <= 1'b0;
         r_rgb  <= '0;
      end else if (i_pix_ce) begin
         r_win1 <= r_fbRdEn;
         r_hs1  <= w_hsync0;
         r_vs1  <= w_vsync0;
         r_de1  <= w_de0;
         r_hs2  <= r_hs1;
         r_vs2  <= r_vs1;
         r_de2  <= r_de1;
         r_rgb  <= r_win1 ? w_palRgb : 12'h000;
      end
   end

   assign w_unusedBits  = ^{i_fb_data[7:6], w_col[9], w_col[0], w_vNext[9], w_vNext[0]};

   assign o_fb_addr     = r_fbAddr;
   assign o_fb_rd_en    = r_fbRdEn;
   assign o_vga_done    = r_vgaDone;
   assign o_frame_start = r_frameStart;
   assign o_hsync       = r_hs2;
   assign o_vsync       = r_vs2;
   assign o_de          = r_de2;
   assign o_red         = r_rgb[11:8];
   assign o_green       = r_rgb[7:4];
   assign o_blue        = r_rgb[3:0];

endmodule

// File: tb/tb_ppu_vga_scanout.sv
// Directed bench for ppu_vga_scanout: full-size instance plus a short-frame instance for vblank behaviour.
module tb_ppu_vga_scanout;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_ce = 1'b0;
   logic [7:0]  fb_data = 8'h00;
   logic [15:0] fb_addr;
   logic        fb_rd_en, vga_done, frame_start, hsync, vsync, de;
   logic [3:0]  red, green, blue;
   logic [11:0] rgb;

   logic [15:0] s_fb_addr;
   logic        s_fb_rd_en, s_vga_done, s_frame_start, s_hsync, s_vsync, s_de;
   logic [3:0]  s_red, s_green, s_blue;

   logic [7:0]  fbMem [0:65535];
   logic [33:0] outBus;
   localparam logic [33:0] RESET_BUS = {16'h0000, 6'b000110, 12'h000};

   int checks = 0;
   int errors = 0;
   int tbH = 0, tbV = 0, sH = 0, sV = 0;

   always #5 clk = ~clk;

   assign rgb    = {red, green, blue};
   assign outBus = {fb_addr, fb_rd_en, vga_done, frame_start, hsync, vsync, de, rgb};

   // Frame buffer model: registered read, one pix_ce latency
   always @(posedge clk) begin
      if (pix_ce && fb_rd_en) fb_data <= fbMem[fb_addr];
   end

   ppu_vga_scanout dut (
      .clk(clk), .rst(rst), .i_pix_ce(pix_ce),
      .o_fb_addr(fb_addr), .o_fb_rd_en(fb_rd_en), .i_fb_data(fb_data),
      .o_vga_done(vga_done), .o_frame_start(frame_start),
      .o_hsync(hsync), .o_vsync(vsync), .o_de(de),
      .o_red(red), .o_green(green), .o_blue(blue)
   );

   // Short frame: 6 visible lines, 10 total, 8000 pix_ce per frame
   ppu_vga_scanout #(.V_VIS(6), .V_FP(2), .V_SYNC(1), .V_BP(1)) dutSmall (
      .clk(clk), .rst(rst), .i_pix_ce(pix_ce),
      .o_fb_addr(s_fb_addr), .o_fb_rd_en(s_fb_rd_en), .i_fb_data(8'h00),
      .o_vga_done(s_vga_done), .o_frame_start(s_frame_start),
      .o_hsync(s_hsync), .o_vsync(s_vsync), .o_de(s_de),
      .o_red(s_red), .o_green(s_green), .o_blue(s_blue)
   );

   task automatic advance();
      tbH++;
      if (tbH == 800) begin
         tbH = 0;
         tbV = (tbV == 524) ? 0 : tbV + 1;
      end
      sH++;
      if (sH == 800) begin
         sH = 0;
         sV = (sV == 9) ? 0 : sV + 1;
      end
   endtask

   // n pix_ce pulses, each preceded by gap idle clocks during which outputs must not move
   task automatic stepCe(input int n, input int gap);
      logic [33:0] snap;
      for (int i = 0; i < n; i++) begin
         snap = outBus;
         for (int g = 0; g < gap; g++) begin
            pix_ce = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (outBus !== snap) begin
               errors++;
               $display("[TB] FAIL ce_hold v=%0d h=%0d: got %h expected %h", tbV, tbH, outBus, snap);
            end
         end
         pix_ce = 1'b1;
         @(posedge clk); #1;
         pix_ce = 1'b0;
         advance();
      end
   endtask

   task automatic runTo(input int v, input int h);
      int n;
      n = ((v * 800 + h) - (tbV * 800 + tbH) + 420000) % 420000;
      stepCe(n, 0);
   endtask

   task automatic runSmallTo(input int v, input int h);
      int n;
      n = ((v * 800 + h) - (sV * 800 + sH) + 8000) % 8000;
      stepCe(n, 0);
   endtask

   task automatic doReset();
      rst = 1'b0;
      pix_ce = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      pix_ce = 1'b0;
      tbH = 0; tbV = 0; sH = 0; sV = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      pix_ce = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (outBus !== RESET_BUS) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", outBus, RESET_BUS);
      end
      checks++;
      if (s_vga_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_small_done: got %b expected 0", s_vga_done);
      end
      rst = 1'b1;
      pix_ce = 1'b0;
      tbH = 0; tbV = 0; sH = 0; sV = 0;
      stepCe(1, 0);
      checks++;
      if (de !== 1'b0) begin
         errors++;
         $display("[TB] FAIL de_latency_1: got %b expected 0", de);
      end
      stepCe(1, 0);
      checks++;
      if (de !== 1'b1) begin
         errors++;
         $display("[TB] FAIL de_latency_2: got %b expected 1", de);
      end
      stepCe(640, 0);
      checks++;
      if (de !== 1'b0) begin
         errors++;
         $display("[TB] FAIL de_end_h640: got %b expected 0", de);
      end
      stepCe(15, 0);
      checks++;
      if (hsync !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hsync_before_fall: got %b expected 1", hsync);
      end
      stepCe(1, 0);
      checks++;
      if (hsync !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hsync_fall_658: got %b expected 0", hsync);
      end
   endtask

   task automatic test_window_addr();
      doReset();
      stepCe(63, 0);
      checks++;
      if (fb_rd_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_en_h63: got %b expected 0", fb_rd_en);
      end
      stepCe(1, 0);
      checks++;
      if ({fb_rd_en, fb_addr} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("[TB] FAIL addr_h64: got en=%b addr=%h expected en=1 addr=0000", fb_rd_en, fb_addr);
      end
      stepCe(1, 0);
      checks++;
      if ({fb_rd_en, fb_addr} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("[TB] FAIL addr_h65: got en=%b addr=%h expected en=1 addr=0000", fb_rd_en, fb_addr);
      end
      stepCe(1, 0);
      checks++;
      if ({fb_rd_en, fb_addr} !== {1'b1, 16'h0001}) begin
         errors++;
         $display("[TB] FAIL addr_h66: got en=%b addr=%h expected en=1 addr=0001", fb_rd_en, fb_addr);
      end
      runTo(0, 575);
      checks++;
      if ({fb_rd_en, fb_addr} !== {1'b1, 16'h00FF}) begin
         errors++;
         $display("[TB] FAIL addr_h575: got en=%b addr=%h expected en=1 addr=00ff", fb_rd_en, fb_addr);
      end
      stepCe(1, 0);
      checks++;
      if ({fb_rd_en, fb_addr} !== {1'b0, 16'h00FF}) begin
         errors++;
         $display("[TB] FAIL addr_hold_h576: got en=%b addr=%h expected en=0 addr=00ff", fb_rd_en, fb_addr);
      end
      runTo(3, 64);
      checks++;
      if ({fb_rd_en, fb_addr, vga_done} !== {1'b1, 16'h0100, 1'b0}) begin
         errors++;
         $display("[TB] FAIL addr_v3_h64: got en=%b addr=%h done=%b expected en=1 addr=0100 done=0", fb_rd_en, fb_addr, vga_done);
      end
   endtask

   task automatic test_palette();
      doReset();
      runTo(0, 12);
      checks++;
      if ({de, rgb} !== {1'b1, 12'h000}) begin
         errors++;
         $display("[TB] FAIL border_h10: got de=%b rgb=%h expected de=1 rgb=000", de, rgb);
      end
      runTo(0, 65);
      checks++;
      if (rgb !== 12'h000) begin
         errors++;
         $display("[TB] FAIL border_h63: got %h expected 000", rgb);
      end
      stepCe(1, 0);
      checks++;
      if (rgb !== 12'hFFF) begin
         errors++;
         $display("[TB] FAIL rgb_h64_idx30: got %h expected fff", rgb);
      end
      stepCe(1, 0);
      checks++;
      if (rgb !== 12'hFFF) begin
         errors++;
         $display("[TB] FAIL rgb_h65_double: got %h expected fff", rgb);
      end
      stepCe(1, 0);
      checks++;
      if (rgb !== 12'h777) begin
         errors++;
         $display("[TB] FAIL rgb_h66_idx00: got %h expected 777", rgb);
      end
      runTo(0, 70);
      checks++;
      if (rgb !== 12'hF30) begin
         errors++;
         $display("[TB] FAIL rgb_h68_idx16: got %h expected f30", rgb);
      end
      runTo(0, 76);
      checks++;
      if (rgb !== 12'hFFF) begin
         errors++;
         $display("[TB] FAIL rgb_h74_dataF0: got %h expected fff", rgb);
      end
      runTo(0, 78);
      checks++;
      if (rgb !== 12'h00F) begin
         errors++;
         $display("[TB] FAIL rgb_h76_data41: got %h expected 00f", rgb);
      end
      runTo(0, 578);
      checks++;
      if ({de, rgb} !== {1'b1, 12'h000}) begin
         errors++;
         $display("[TB] FAIL border_h576: got de=%b rgb=%h expected de=1 rgb=000", de, rgb);
      end
   endtask

   task automatic test_vga_done();
      int badCount;
      int period;
      doReset();
      runSmallTo(5, 575);
      checks++;
      if ({s_fb_rd_en, s_vga_done} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL last_read_v5: got en=%b done=%b expected en=1 done=0", s_fb_rd_en, s_vga_done);
      end
      runSmallTo(5, 799);
      checks++;
      if (s_vga_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_before_vvis: got %b expected 0", s_vga_done);
      end
      stepCe(1, 0);
      checks++;
      if ({s_vga_done, s_fb_rd_en, s_frame_start} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL done_rise_v6: got done/en/fs=%b%b%b expected 100", s_vga_done, s_fb_rd_en, s_frame_start);
      end
      badCount = 0;
      for (int i = 0; i < 3199; i++) begin
         stepCe(1, 0);
         if (s_fb_rd_en || !s_vga_done || s_frame_start) badCount++;
      end
      checks++;
      if (badCount !== 0) begin
         errors++;
         $display("[TB] FAIL vblank_quiet: got %0d bad cycles expected 0", badCount);
      end
      stepCe(1, 0);
      checks++;
      if ({s_vga_done, s_frame_start} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL done_fall_wrap: got done=%b fs=%b expected done=0 fs=1", s_vga_done, s_frame_start);
      end
      stepCe(1, 0);
      checks++;
      if ({s_vga_done, s_frame_start} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL frame_start_width: got done=%b fs=%b expected done=0 fs=0", s_vga_done, s_frame_start);
      end
      period = 1;
      while (!s_frame_start && period <= 9000) begin
         stepCe(1, 0);
         period++;
      end
      checks++;
      if (period != 8000) begin
         errors++;
         $display("[TB] FAIL frame_period: got %0d expected 8000", period);
      end
   endtask

   task automatic test_ce_duty();
      doReset();
      stepCe(64, 3);
      checks++;
      if ({fb_rd_en, fb_addr} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("[TB] FAIL duty_addr_h64: got en=%b addr=%h expected en=1 addr=0000", fb_rd_en, fb_addr);
      end
      stepCe(2, 3);
      checks++;
      if ({fb_addr, rgb} !== {16'h0001, 12'hFFF}) begin
         errors++;
         $display("[TB] FAIL duty_h66: got addr=%h rgb=%h expected addr=0001 rgb=fff", fb_addr, rgb);
      end
      stepCe(2, 3);
      checks++;
      if (rgb !== 12'h777) begin
         errors++;
         $display("[TB] FAIL duty_rgb_h68: got %h expected 777", rgb);
      end
   endtask

   task automatic test_reset_midframe();
      doReset();
      runTo(16, 300);
      checks++;
      if ({fb_rd_en, s_vga_done} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL pre_reset_state: got en=%b small_done=%b expected 11", fb_rd_en, s_vga_done);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({outBus, s_vga_done} !== {RESET_BUS, 1'b0}) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h/%b expected %h/0", outBus, s_vga_done, RESET_BUS);
      end
      pix_ce = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (outBus !== RESET_BUS) begin
         errors++;
         $display("[TB] FAIL reset_hold: got %h expected %h", outBus, RESET_BUS);
      end
      rst = 1'b1;
      pix_ce = 1'b0;
      tbH = 0; tbV = 0; sH = 0; sV = 0;
      stepCe(64, 0);
      checks++;
      if ({fb_rd_en, fb_addr, vga_done} !== {1'b1, 16'h0000, 1'b0}) begin
         errors++;
         $display("[TB] FAIL restart_h64: got en=%b addr=%h done=%b expected en=1 addr=0000 done=0", fb_rd_en, fb_addr, vga_done);
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) fbMem[a] = 8'h00;
      fbMem[16'h0000] = 8'h30;
      fbMem[16'h0002] = 8'h16;
      fbMem[16'h0005] = 8'hF0;
      fbMem[16'h0006] = 8'h41;
      test_reset();
      test_window_addr();
      test_palette();
      test_vga_done();
      test_ce_duty();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
